alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 166 ++++++++++++++++
 tb/tb_alu_pipe.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage accumulator ALU with valid/ready handshakes on both sides.
// Stage 1 captures the request, and stage 2 captures the result and its flags.
// A full stage 2 that retires in the same cycle can accept a new result, so
// the pipe sustains one transaction per clock.

package typedefs_pkg;
  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;
endpackage

module alu_pipe
  import typedefs_pkg::*;
#(
  parameter int unsigned WIDTH   = 32'd8,
  parameter int unsigned SAT_ADD = 32'd0
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             in_valid,
  output logic             in_ready,
  input  opcode_t          opcode,
  input  logic [WIDTH-1:0] accum,
  input  logic [WIDTH-1:0] data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry,
  output logic             ovf
);

  // Stage 1 holds the request payload.
  logic             s1_valid_q, s1_valid_d;
  opcode_t          s1_op_q,    s1_op_d;
  logic [WIDTH-1:0] s1_acc_q,   s1_acc_d;
  logic [WIDTH-1:0] s1_data_q,  s1_data_d;

  // Stage 2 holds the result presented on the output ports.
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q,       out_d;
  logic             zero_q,      zero_d;
  logic             carry_q,     carry_d;
  logic             ovf_q,       ovf_d;

  logic             s2_load_s;
  logic             in_fire_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] res_out_s;
  logic             res_zero_s;
  logic             res_carry_s;
  logic             res_ovf_s;

  // Handshake decisions. in_ready depends only on pipe state and out_ready, not on in_valid.
  always_comb begin
    s2_load_s = s1_valid_q && (!out_valid_q || out_ready);
    in_ready  = !s1_valid_q || s2_load_s;
    in_fire_s = in_valid && in_ready;
  end

  // Compute the ALU result and flags from stage 1 contents.
  always_comb begin
    sum_s       = {1'b0, s1_acc_q} + {1'b0, s1_data_q};
    res_out_s   = '0;
    res_carry_s = 1'b0;
    res_ovf_s   = 1'b0;
    res_zero_s  = (s1_acc_q == '0);
    case (s1_op_q)
      HLT, SKZ, STO, JMP: res_out_s = s1_acc_q;
      ADD: begin
        res_carry_s = sum_s[WIDTH];
        // Overflow is taken from the raw sum even when the result saturates.
        res_ovf_s   = (s1_acc_q[WIDTH-1] == s1_data_q[WIDTH-1]) &&
                      (sum_s[WIDTH-1] != s1_acc_q[WIDTH-1]);
        if ((SAT_ADD != 32'd0) && sum_s[WIDTH]) begin
          res_out_s = '1;
        end else begin
          res_out_s = sum_s[WIDTH-1:0];
        end
      end
      AND:     res_out_s = s1_acc_q & s1_data_q;
      XOR:     res_out_s = s1_acc_q ^ s1_data_q;
      LDA:     res_out_s = s1_data_q;
      default: begin
        res_out_s   = '0;
        res_carry_s = 1'b0;
        res_ovf_s   = 1'b0;
      end
    endcase
  end

  // Next-state logic for both stages. Stage 2 is left untouched while it stalls, so its outputs stay stable.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_acc_d    = s1_acc_q;
    s1_data_d   = s1_data_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;

    if (in_fire_s) begin
      s1_valid_d = 1'b1;
      s1_op_d    = opcode;
      s1_acc_d   = accum;
      s1_data_d  = data;
    end else if (s2_load_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s2_load_s) begin
      out_valid_d = 1'b1;
      out_d       = res_out_s;
      zero_d      = res_zero_s;
      carry_d     = res_carry_s;
      ovf_d       = res_ovf_s;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline registers with synchronous active-low reset that discards in-flight work.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= HLT;
      s1_acc_q    <= '0;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_acc_q    <= s1_acc_d;
      s1_data_q   <= s1_data_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe. The main instance (WIDTH=8, wrapping ADD) runs with
// a queue scoreboard and a reference model. Two smaller instances cover
// saturating ADD, WIDTH=16 arithmetic and reset with transactions in flight.
module tb_alu_pipe;
  import typedefs_pkg::*;

  typedef struct {
    logic [31:0] out;
    logic        zero;
    logic        carry;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a: WIDTH=8, SAT_ADD=0
  logic rst_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, zero_a, carry_a, ovf_a;
  opcode_t op_a;
  logic [7:0] acc_a, data_a, out_a;
  // Instance b: WIDTH=8, SAT_ADD=1
  logic rst_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, zero_b, carry_b, ovf_b;
  opcode_t op_b;
  logic [7:0] acc_b, data_b, out_b;
  // Instance c: WIDTH=16, SAT_ADD=0
  logic rst_c, in_valid_c, in_ready_c, out_valid_c, out_ready_c, zero_c, carry_c, ovf_c;
  opcode_t op_c;
  logic [15:0] acc_c, data_c, out_c;

  alu_pipe #(.WIDTH(8), .SAT_ADD(0)) dut_a (
    .clk(clk), .rst_(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a), .opcode(op_a),
    .accum(acc_a), .data(data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out(out_a), .zero(zero_a), .carry(carry_a), .ovf(ovf_a));
  alu_pipe #(.WIDTH(8), .SAT_ADD(1)) dut_b (
    .clk(clk), .rst_(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b), .opcode(op_b),
    .accum(acc_b), .data(data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out(out_b), .zero(zero_b), .carry(carry_b), .ovf(ovf_b));
  alu_pipe #(.WIDTH(16), .SAT_ADD(0)) dut_c (
    .clk(clk), .rst_(rst_c), .in_valid(in_valid_c), .in_ready(in_ready_c), .opcode(op_c),
    .accum(acc_c), .data(data_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
    .out(out_c), .zero(zero_c), .carry(carry_c), .ovf(ovf_c));

  exp_t sb[$];
  int   pop_cyc[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic hold_v = 1'b0;
  exp_t held;
  exp_t mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic exp_t model(opcode_t op, longint a, longint d, int w, bit sat);
    exp_t   e;
    longint full, sum, sa, sd, ss;
    full    = longint'(1) << w;
    sum     = a + d;
    sa      = (a >= full / 2) ? a - full : a;
    sd      = (d >= full / 2) ? d - full : d;
    ss      = sa + sd;
    e.zero  = (a == 0);
    e.carry = 1'b0;
    e.ovf   = 1'b0;
    case (op)
      ADD: begin
        e.carry = (sum >= full);
        e.ovf   = (ss >= full / 2) || (ss < -(full / 2));
        e.out   = (sat && e.carry) ? 32'(full - 1) : 32'(sum % full);
      end
      AND:     e.out = 32'(a & d);
      XOR:     e.out = 32'(a ^ d);
      LDA:     e.out = 32'(d);
      default: e.out = 32'(a);
    endcase
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every output handshake and checks stall stability.
  always @(negedge clk) begin
    if (!rst_a) begin
      hold_v <= 1'b0;
    end else begin
      if (hold_v) begin
        chk("stall_valid", 32'(out_valid_a), 32'd1);
        chk("stall_out", 32'(out_a), held.out);
        chk("stall_flags", 32'({zero_a, carry_a, ovf_a}), 32'({held.zero, held.carry, held.ovf}));
      end
      if (out_valid_a && out_ready_a) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got out=%0h with nothing outstanding", out_a);
        end else begin
          mon_e = sb.pop_front();
          chk("out", 32'(out_a), mon_e.out);
          chk("zero", 32'(zero_a), 32'(mon_e.zero));
          chk("carry", 32'(carry_a), 32'(mon_e.carry));
          chk("ovf", 32'(ovf_a), 32'(mon_e.ovf));
          pop_cyc.push_back(cyc);
        end
      end
      hold_v    <= out_valid_a && !out_ready_a;
      held.out  <= 32'(out_a);
      held.zero <= zero_a;
      held.carry <= carry_a;
      held.ovf  <= ovf_a;
    end
  end

  // One cycle of stimulus on instance a; pushes the model result if the request is accepted.
  task automatic drive_a(input bit v, input opcode_t op, input logic [7:0] a, input logic [7:0] d,
                         output bit acc);
    in_valid_a = v;
    op_a       = op;
    acc_a      = a;
    data_a     = d;
    @(negedge clk);
    acc = v && in_ready_a;
    if (acc) sb.push_back(model(op, longint'(a), longint'(d), 8, 1'b0));
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input opcode_t op, input logic [7:0] a, input logic [7:0] d);
    bit ok = 1'b0;
    int tries = 0;
    while (!ok && tries < 100) begin
      drive_a(1'b1, op, a, d, ok);
      tries++;
    end
    in_valid_a = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0 for 100 cycles expected acceptance");
    end
  endtask

  task automatic drain_a();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic aux_b(input string nm, input opcode_t op, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] eo, input bit ec, input bit ev);
    bit seen = 1'b0;
    in_valid_b = 1'b1; op_b = op; acc_b = a; data_b = d;
    @(negedge clk);
    chk({nm, "_rdy"}, 32'(in_ready_b), 32'd1);
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (out_valid_b) begin
        seen = 1'b1;
        chk({nm, "_out"}, 32'(out_b), 32'(eo));
        chk({nm, "_carry"}, 32'(carry_b), 32'(ec));
        chk({nm, "_ovf"}, 32'(ovf_b), 32'(ev));
      end
    end
    chk({nm, "_seen"}, 32'(seen), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic aux_c(input string nm, input opcode_t op, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] eo, input bit ec, input bit ev, input bit ez);
    bit seen = 1'b0;
    in_valid_c = 1'b1; op_c = op; acc_c = a; data_c = d;
    @(negedge clk);
    chk({nm, "_rdy"}, 32'(in_ready_c), 32'd1);
    @(posedge clk);
    #1;
    in_valid_c = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (out_valid_c) begin
        seen = 1'b1;
        chk({nm, "_out"}, 32'(out_c), 32'(eo));
        chk({nm, "_carry"}, 32'(carry_c), 32'(ec));
        chk({nm, "_ovf"}, 32'(ovf_c), 32'(ev));
        chk({nm, "_zero"}, 32'(zero_c), 32'(ez));
      end
    end
    chk({nm, "_seen"}, 32'(seen), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected completion within 500us");
    $fatal(1);
  end

  initial begin
    bit ok;
    int acc_cnt;
    int n;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    in_valid_a = 1'b0; in_valid_b = 1'b0; in_valid_c = 1'b0;
    out_ready_a = 1'b1; out_ready_b = 1'b1; out_ready_c = 1'b1;
    op_a = HLT; op_b = HLT; op_c = HLT;
    acc_a = 8'h00; data_a = 8'h00; acc_b = 8'h00; data_b = 8'h00;
    acc_c = 16'h0000; data_c = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid_a), 32'd0);
    chk("rst_out", 32'(out_a), 32'd0);
    chk("rst_flags", 32'({zero_a, carry_a, ovf_a}), 32'd0);
    @(posedge clk);
    #1;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready_a), 32'd1);
    @(posedge clk);
    #1;

    // Signed overflow and wrapping carry
    send_a(ADD, 8'h7F, 8'h01);
    send_a(ADD, 8'hF0, 8'h20);
    drain_a();

    // Back-to-back LDA / AND / XOR must retire on consecutive cycles
    send_a(LDA, 8'h00, 8'hA5);
    send_a(AND, 8'hFF, 8'h0F);
    send_a(XOR, 8'hAA, 8'h55);
    drain_a();
    n = pop_cyc.size();
    chk("b2b_gap1", 32'(pop_cyc[n-2] - pop_cyc[n-3]), 32'd1);
    chk("b2b_gap2", 32'(pop_cyc[n-1] - pop_cyc[n-2]), 32'd1);

    // Zero flag follows the accumulator of the transaction in out
    send_a(SKZ, 8'h00, 8'h77);
    send_a(JMP, 8'h3C, 8'h00);
    send_a(STO, 8'h81, 8'h18);
    send_a(HLT, 8'h00, 8'hFF);
    drain_a();

    // Backpressure: five cycles of offered requests, only two fit
    out_ready_a = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b1, opcode_t'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), ok);
      if (ok) acc_cnt++;
    end
    in_valid_a = 1'b0;
    chk("bp_accepts", 32'(acc_cnt), 32'd2);
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready_a), 32'd0);
    @(posedge clk);
    #1;
    out_ready_a = 1'b1;
    drain_a();

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      out_ready_a = ($urandom_range(0, 9) < 7);
      drive_a($urandom_range(0, 9) < 7, opcode_t'($urandom_range(0, 7)), 8'($urandom),
              8'($urandom), ok);
    end
    in_valid_a = 1'b0;
    out_ready_a = 1'b1;
    drain_a();

    // Reset with two transactions in flight: nothing may emerge afterwards
    out_ready_a = 1'b0;
    send_a(ADD, 8'h11, 8'h22);
    send_a(XOR, 8'h0F, 8'hF0);
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_a = 1'b1;
    out_ready_a = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid_a), 32'd0);
    chk("midrst_in_ready", 32'(in_ready_a), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    send_a(AND, 8'h5A, 8'h3C);
    drain_a();

    // Saturating ADD instance
    aux_b("sat_add", ADD, 8'hF0, 8'h20, 8'hFF, 1'b1, 1'b0);
    aux_b("sat_ovf", ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    aux_b("sat_negovf", ADD, 8'h80, 8'h80, 8'hFF, 1'b1, 1'b1);

    // WIDTH=16 instance
    aux_c("w16_add", ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0);
    out_ready_c = 1'b0;
    in_valid_c = 1'b1; op_c = LDA; acc_c = 16'h1234; data_c = 16'hBEEF;
    @(posedge clk);
    #1;
    op_c = XOR; acc_c = 16'h00FF; data_c = 16'hFF00;
    @(posedge clk);
    #1;
    in_valid_c = 1'b0;
    @(negedge clk);
    chk("w16_inflight_valid", 32'(out_valid_c), 32'd1);
    chk("w16_inflight_ready", 32'(in_ready_c), 32'd0);
    @(posedge clk);
    #1;
    rst_c = 1'b0;
    @(posedge clk);
    #1;
    rst_c = 1'b1;
    out_ready_c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("w16_no_stale", 32'(out_valid_c), 32'd0);
    end
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
